router_sync_n: RTL and testbench

Parametrised successor to the 1x3 router synchroniser. It latches the destination address on `detect_add` and steers `write_enb_reg` to one of `NUM_PORTS` output FIFOs. It muxes the selected FIFO's full flag back to the FSM and drives per-port `vld_out` from the FIFO empty flags. A per-port idle-timeout counter issues `soft_reset` pulses. Unlike the fixed 1x3 version, it flags out-of-range addresses, suppresses writes to them, and makes the timeout configurable. It sits between the router FSM/register block and the `NUM_PORTS` output FIFOs.

---
 rtl/router_sync_n.sv | 72 +++++++
 tb/tb_router_sync_n.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/router_sync_n.sv
// rtl/router_sync_n.sv - parametrised router synchroniser: address latch, write steer, full mux, idle timeout
module router_sync_n #(
    parameter int NUM_PORTS = 3,
    parameter int TIMEOUT   = 30,
    localparam int ADDR_W   = $clog2(NUM_PORTS),
    localparam int CNT_W    = $clog2(TIMEOUT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 detect_add,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 write_enb_reg,
    input  logic [NUM_PORTS-1:0] full,
    input  logic [NUM_PORTS-1:0] empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 fifo_full,
    output logic                 addr_err,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset
);

    logic [ADDR_W-1:0] addr_q;
    logic              addr_ok;
    logic [CNT_W-1:0]  cnt [NUM_PORTS];

    // Latch the header address and remember whether it names a real port.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            addr_ok <= 1'b1;
        end else if (detect_add) begin
            addr_q  <= data_in;
            addr_ok <= ({1'b0, data_in} < (ADDR_W+1)'(NUM_PORTS));
        end
    end

    // Steer the write strobe and return the addressed full flag; a bad address selects nothing.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_ok && (addr_q == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign addr_err = ~addr_ok;
    assign vld_out  = ~empty;

    // Per-port idle counters: any read or empty FIFO restarts the count; a full count flushes the FIFO.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (reset) begin
                cnt[i]        <= '0;
                soft_reset[i] <= 1'b0;
            end else if (!vld_out[i] || read_enb[i]) begin
                cnt[i]        <= '0;
                soft_reset[i] <= 1'b0;
            end else if (cnt[i] == CNT_W'(TIMEOUT - 1)) begin
                cnt[i]        <= '0;
                soft_reset[i] <= 1'b1;
            end else begin
                cnt[i]        <= cnt[i] + CNT_W'(1);
                soft_reset[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_sync_n.sv
// tb/tb_router_sync_n.sv - checks two router_sync_n configurations against a behavioural model
module tb_router_sync_n;

    logic       clock = 1'b0;
    logic       reset;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [3:0] full, empty, read_enb;

    logic [2:0] we_a, vld_a, sr_a;
    logic       ff_a, err_a;
    logic [3:0] we_b, vld_b, sr_b;
    logic       ff_b, err_b;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    always #5 clock = ~clock;

    router_sync_n #(.NUM_PORTS(3), .TIMEOUT(30)) dut_a (
        .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
        .write_enb_reg(write_enb_reg), .full(full[2:0]), .empty(empty[2:0]),
        .read_enb(read_enb[2:0]), .write_enb(we_a), .fifo_full(ff_a),
        .addr_err(err_a), .vld_out(vld_a), .soft_reset(sr_a)
    );

    router_sync_n #(.NUM_PORTS(4), .TIMEOUT(5)) dut_b (
        .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
        .write_enb_reg(write_enb_reg), .full(full), .empty(empty),
        .read_enb(read_enb), .write_enb(we_b), .fifo_full(ff_b),
        .addr_err(err_b), .vld_out(vld_b), .soft_reset(sr_b)
    );

    // model: instance 0 = (3 ports, timeout 30), instance 1 = (4 ports, timeout 5)
    int np [2] = '{3, 4};
    int to [2] = '{30, 5};
    int addr_m [2];
    bit ok_m [2];
    int run [2][4];
    bit sr_m [2][4];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: address register plus length of the current run of idle edges per port.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                addr_m[k] = 0;
                ok_m[k]   = 1;
                for (int i = 0; i < 4; i++) begin run[k][i] = 0; sr_m[k][i] = 0; end
            end else begin
                if (detect_add) begin
                    addr_m[k] = int'(data_in);
                    ok_m[k]   = int'(data_in) < np[k];
                end
                for (int i = 0; i < np[k]; i++) begin
                    if (!empty[i] && !read_enb[i]) begin
                        run[k][i]  = run[k][i] + 1;
                        sr_m[k][i] = (run[k][i] % to[k]) == 0;
                    end else begin
                        run[k][i]  = 0;
                        sr_m[k][i] = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] e_we, e_vld, e_sr, a_we, a_vld, a_sr;
                logic e_ff, a_ff, a_err;
                e_we = 0; e_vld = 0; e_sr = 0;
                e_ff = ok_m[k] ? full[addr_m[k]] : 1'b0;
                for (int i = 0; i < np[k]; i++) begin
                    e_we[i]  = write_enb_reg && ok_m[k] && (addr_m[k] == i);
                    e_vld[i] = !empty[i];
                    e_sr[i]  = sr_m[k][i];
                end
                if (k == 0) begin
                    a_we = {1'b0, we_a}; a_vld = {1'b0, vld_a}; a_sr = {1'b0, sr_a};
                    a_ff = ff_a; a_err = err_a;
                end else begin
                    a_we = we_b; a_vld = vld_b; a_sr = sr_b;
                    a_ff = ff_b; a_err = err_b;
                end
                check($sformatf("m%0d write_enb", k), a_we, e_we);
                check($sformatf("m%0d fifo_full", k), {3'b0, a_ff}, {3'b0, e_ff});
                check($sformatf("m%0d addr_err", k), {3'b0, a_err}, {3'b0, !ok_m[k]});
                check($sformatf("m%0d vld_out", k), a_vld, e_vld);
                check($sformatf("m%0d soft_reset", k), a_sr, e_sr);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; detect_add = 0; data_in = 0; write_enb_reg = 0;
        full = 0; empty = 4'b1111; read_enb = 0;
        tick();
        chk_en = 1;
        tick();
        #1;
        check("reset soft_reset_a", {1'b0, sr_a}, 4'b0000);
        check("reset addr_err_a", {3'b0, err_a}, 4'b0000);

        // port-0 write
        reset = 0; detect_add = 1; data_in = 0;
        tick();
        detect_add = 0; write_enb_reg = 1;
        #1;
        check("port0 we_a", {1'b0, we_a}, 4'b0001);
        check("port0 we_b", we_b, 4'b0001);
        tick();

        // full mux
        write_enb_reg = 0; detect_add = 1; data_in = 2; full = 4'b0100;
        tick();
        detect_add = 0;
        #1;
        check("fullmux ff_a hi", {3'b0, ff_a}, 4'b0001);
        full = 4'b0011;
        #1;
        check("fullmux ff_a lo", {3'b0, ff_a}, 4'b0000);

        // out-of-range (A) / valid port 3 (B); write in detect cycle uses old address
        detect_add = 1; data_in = 3; write_enb_reg = 1; full = 4'b1111;
        #1;
        check("latency we_a old addr", {1'b0, we_a}, 4'b0100);
        tick();
        detect_add = 0;
        #1;
        check("oor we_a", {1'b0, we_a}, 4'b0000);
        check("oor ff_a", {3'b0, ff_a}, 4'b0000);
        check("oor err_a", {3'b0, err_a}, 4'b0001);
        check("port3 we_b", we_b, 4'b1000);
        check("port3 ff_b", {3'b0, ff_b}, 4'b0001);
        tick(); tick();
        check("oor err_a held", {3'b0, err_a}, 4'b0001);
        detect_add = 1; data_in = 1;
        tick();
        detect_add = 0;
        #1;
        check("recover err_a", {3'b0, err_a}, 4'b0000);
        check("recover we_a", {1'b0, we_a}, 4'b0010);
        write_enb_reg = 0; full = 0;

        // timeout pulse on port 0
        empty = 4'b1110; read_enb = 0;
        for (int e = 1; e <= 61; e++) begin
            tick();
            if (e == 5)  check("b first pulse", sr_b, 4'b0001);
            if (e == 29) check("a no early pulse", {1'b0, sr_a}, 4'b0000);
            if (e == 30) check("a pulse edge30", {1'b0, sr_a}, 4'b0001);
            if (e == 31) check("a pulse one cycle", {1'b0, sr_a}, 4'b0000);
            if (e == 60) check("a pulse edge60", {1'b0, sr_a}, 4'b0001);
        end

        // a read on the would-be firing edge suppresses the pulse
        empty = 4'b1101;
        for (int e = 1; e <= 60; e++) begin
            read_enb = (e == 30) ? 4'b0010 : 4'b0000;
            tick();
            if (e == 30) check("read suppresses", {1'b0, sr_a}, 4'b0000);
            if (e == 60) check("pulse after read", {1'b0, sr_a}, 4'b0010);
        end
        read_enb = 0;

        // reset mid-count
        empty = 4'b1110;
        for (int e = 1; e <= 51; e++) begin
            reset = (e == 21);
            tick();
            if (e == 21) check("no pulse on reset", {1'b0, sr_a}, 4'b0000);
            if (e == 50) check("mid reset no pulse", {1'b0, sr_a}, 4'b0000);
            if (e == 51) check("mid reset pulse", {1'b0, sr_a}, 4'b0001);
        end
        reset = 0;

        // all ports of B time out together
        empty = 4'b0000; read_enb = 4'b1111;
        tick();
        read_enb = 0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 5) check("b all ports pulse", sr_b, 4'b1111);
        end
        tick();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
